// File: rtl/rv32_pkg.sv
// Shared RV32 core definitions used by the register file and its read ports.
//   XLEN_DEF     default data width
//   REG_ADDR_W   width of a register index field in the ISA encoding
//   NREGS_RV32E  number of integer registers in the RV32E profile
//   reg_idx_t    register index type
//   xword_t      register data word type
//   REG_ZERO     index of the hardwired-zero register x0
package rv32_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int NREGS_RV32E = 16;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [XLEN_DEF-1:0]   xword_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port of the integer register file.
// Decodes the index, gates x0 and out-of-range indices to zero, optionally
// forwards the write port's data, and looks up the pending-write busy bit.
//   addr      read index
//   regs      storage array (x0 entry is always zero)
//   busy_vec  per-register pending-write flags
//   wr_en/wr_addr/wr_data  write port, used for forwarding
//   data      read value
//   busy      register has an outstanding claim
//   illegal   addr is outside the implemented register range
module regfile_rd_port
    import rv32_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_RV32E,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   regs [NREGS],
    input  logic [NREGS-1:0]  busy_vec,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    output logic [XLEN-1:0]   data,
    output logic              busy,
    output logic              illegal
);

    localparam int IDX_W = $clog2(NREGS);

    logic [IDX_W-1:0] idx;
    logic             legal;
    logic             live;
    logic             byp_hit;

    assign idx   = addr[IDX_W-1:0];
    assign legal = int'(addr) < NREGS;
    // Only implemented, non-zero registers return anything but zero.
    assign live  = legal && (addr != ADDR_W'(REG_ZERO));

    // A matching live read implies the write index is live too, so the
    // forward needs no separate range check on wr_addr.
    assign byp_hit = (BYPASS != 0) && wr_en && (wr_addr == addr);

    always_comb begin
        data = '0;
        if (live) begin
            data = byp_hit ? wr_data : regs[idx];
        end
    end

    // Busy is deliberately never forwarded from a same-cycle release.
    assign busy    = live && busy_vec[idx];
    assign illegal = !legal;

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with a per-register pending-write scoreboard.
// Decode reads two sources and claims a destination for long-latency ops;
// writeback writes results and releases claims.
//   clk, rst_n              clock, asynchronous active-low reset
//   rs1_addr/data/busy      read port 1
//   rs2_addr/data/busy      read port 2
//   wr_en/addr/data         write port
//   wr_release              with wr_en, clear the claim on wr_addr
//   claim_en/claim_addr     mark a register as pending
//   claim_ok                claim_addr is not currently busy
//   pending_cnt             number of busy registers (registered)
//   illegal_idx             some active index is outside the register range
module regfile_scoreboard
    import rv32_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_RV32E,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic              rs1_busy,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs2_data,
    output logic              rs2_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              wr_release,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic              claim_ok,
    output logic [ADDR_W-1:0] pending_cnt,
    output logic              illegal_idx
);

    localparam int IDX_W = $clog2(NREGS);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] claim_idx;
    logic             wr_legal;
    logic             claim_legal;
    logic             wr_live;
    logic             rel_live;
    logic             claim_live;
    logic             cnt_inc;
    logic             cnt_dec;
    logic             rs1_illegal;
    logic             rs2_illegal;

    assign wr_idx      = wr_addr[IDX_W-1:0];
    assign claim_idx   = claim_addr[IDX_W-1:0];
    assign wr_legal    = int'(wr_addr) < NREGS;
    assign claim_legal = int'(claim_addr) < NREGS;

    assign wr_live    = wr_en && wr_legal && (wr_addr != ADDR_W'(REG_ZERO));
    assign rel_live   = wr_live && wr_release;
    assign claim_live = claim_en && claim_legal && (claim_addr != ADDR_W'(REG_ZERO));

    regfile_rd_port #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rd1 (
        .addr     (rs1_addr),
        .regs     (regs),
        .busy_vec (busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .data     (rs1_data),
        .busy     (rs1_busy),
        .illegal  (rs1_illegal)
    );

    regfile_rd_port #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rd2 (
        .addr     (rs2_addr),
        .regs     (regs),
        .busy_vec (busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .data     (rs2_data),
        .busy     (rs2_busy),
        .illegal  (rs2_illegal)
    );

    // busy[0] is never set, so x0 reads as free without extra gating.
    assign claim_ok    = !(claim_legal && busy[claim_idx]);
    assign illegal_idx = rs1_illegal || rs2_illegal ||
                         (wr_en && !wr_legal) || (claim_en && !claim_legal);

    // Release is applied first so a same-register claim overrides it.
    // The counter tracks actual 0->1 and 1->0 transitions only.
    always_comb begin
        busy_nxt = busy;
        cnt_inc  = 1'b0;
        cnt_dec  = 1'b0;
        if (rel_live && busy[wr_idx]) begin
            busy_nxt[wr_idx] = 1'b0;
            cnt_dec          = 1'b1;
        end
        if (claim_live) begin
            busy_nxt[claim_idx] = 1'b1;
            if (!busy[claim_idx]) begin
                cnt_inc = 1'b1;
            end
            if (rel_live && (claim_idx == wr_idx)) begin
                cnt_dec = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            busy        <= busy_nxt;
            pending_cnt <= pending_cnt + ADDR_W'(cnt_inc) - ADDR_W'(cnt_dec);
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: three instances share one stimulus stream
// (NREGS=16/BYPASS=1, NREGS=16/BYPASS=0, NREGS=32/BYPASS=1) and are compared
// against an array-based reference model of register contents and claims.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [4:0]  rs1_addr, rs2_addr, wr_addr, claim_addr;
    logic [31:0] wr_data;
    logic        wr_en, wr_release, claim_en;

    logic [2:0][31:0] rs1_data, rs2_data;
    logic [2:0]       rs1_busy, rs2_busy, claim_ok, illegal_idx;
    logic [2:0][4:0]  pending_cnt;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        regfile_scoreboard #(
            .XLEN   (32),
            .NREGS  ((g == 2) ? 32 : 16),
            .ADDR_W (5),
            .BYPASS ((g == 1) ? 0 : 1)
        ) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .rs1_addr    (rs1_addr),
            .rs1_data    (rs1_data[g]),
            .rs1_busy    (rs1_busy[g]),
            .rs2_addr    (rs2_addr),
            .rs2_data    (rs2_data[g]),
            .rs2_busy    (rs2_busy[g]),
            .wr_en       (wr_en),
            .wr_addr     (wr_addr),
            .wr_data     (wr_data),
            .wr_release  (wr_release),
            .claim_en    (claim_en),
            .claim_addr  (claim_addr),
            .claim_ok    (claim_ok[g]),
            .pending_cnt (pending_cnt[g]),
            .illegal_idx (illegal_idx[g])
        );
    end

    int          nregs [3] = '{16, 16, 32};
    bit          byp   [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] m_regs [3][32];
    bit          m_busy [3][32];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit in_range(int k, logic [4:0] a);
        return (a != 5'd0) && (int'(a) < nregs[k]);
    endfunction

    function automatic logic [31:0] exp_rd(int k, logic [4:0] a);
        if (!in_range(k, a)) return 32'd0;
        if (byp[k] && wr_en && (wr_addr == a)) return wr_data;
        return m_regs[k][a];
    endfunction

    function automatic bit exp_busy(int k, logic [4:0] a);
        return in_range(k, a) && m_busy[k][a];
    endfunction

    function automatic int popcnt(int k);
        int n = 0;
        for (int i = 0; i < 32; i++) if (m_busy[k][i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 32; i++) begin
                m_regs[k][i] = 32'd0;
                m_busy[k][i] = 1'b0;
            end
    endtask

    task automatic model_update();
        if (!rst_n) return;
        for (int k = 0; k < 3; k++) begin
            if (wr_en && in_range(k, wr_addr)) m_regs[k][wr_addr] = wr_data;
            if (wr_en && wr_release && in_range(k, wr_addr)) m_busy[k][wr_addr] = 1'b0;
            if (claim_en && in_range(k, claim_addr)) m_busy[k][claim_addr] = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        bit il;
        for (int k = 0; k < 3; k++) begin
            il = (int'(rs1_addr) >= nregs[k]) || (int'(rs2_addr) >= nregs[k]) ||
                 (wr_en && int'(wr_addr) >= nregs[k]) ||
                 (claim_en && int'(claim_addr) >= nregs[k]);
            chk($sformatf("%s.rs1_data[%0d]", tag, k), rs1_data[k], exp_rd(k, rs1_addr));
            chk($sformatf("%s.rs2_data[%0d]", tag, k), rs2_data[k], exp_rd(k, rs2_addr));
            chk($sformatf("%s.rs1_busy[%0d]", tag, k), 32'(rs1_busy[k]), 32'(exp_busy(k, rs1_addr)));
            chk($sformatf("%s.rs2_busy[%0d]", tag, k), 32'(rs2_busy[k]), 32'(exp_busy(k, rs2_addr)));
            chk($sformatf("%s.claim_ok[%0d]", tag, k), 32'(claim_ok[k]), 32'(!exp_busy(k, claim_addr)));
            chk($sformatf("%s.pending[%0d]", tag, k), 32'(pending_cnt[k]), popcnt(k));
            chk($sformatf("%s.illegal[%0d]", tag, k), 32'(illegal_idx[k]), 32'(il));
        end
    endtask

    task automatic idle();
        rs1_addr = 5'd0; rs2_addr = 5'd0; wr_addr = 5'd0; claim_addr = 5'd0;
        wr_data = 32'd0; wr_en = 1'b0; wr_release = 1'b0; claim_en = 1'b0;
    endtask

    // Inputs are set just after a falling edge; outputs are checked 1ns later,
    // then the model advances on the rising edge.
    task automatic cycle(input string tag);
        #1 check_all(tag);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 7) == 0) return 5'($urandom_range(16, 31));
        return 5'($urandom_range(0, 15));
    endfunction

    task automatic rnd_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            wr_en      = $urandom_range(0, 1) == 1;
            wr_addr    = rnd_addr();
            wr_data    = $urandom;
            wr_release = $urandom_range(0, 2) != 0;
            claim_en   = $urandom_range(0, 2) == 0;
            claim_addr = rnd_addr();
            rs1_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : rnd_addr();
            rs2_addr   = ($urandom_range(0, 3) == 0) ? claim_addr : rnd_addr();
            cycle("rnd");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        #1 check_all("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // write / read and x0
        idle(); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; cycle("t2w5");
        wr_addr = 5'd0; wr_data = 32'h00001234; cycle("t2w0");
        idle(); rs1_addr = 5'd5; rs2_addr = 5'd0;
        #1 chk("t2_rs1", rs1_data[0], 32'hDEADBEEF);
        chk("t2_rs2_x0", rs2_data[0], 32'd0);
        cycle("t2r");

        // bypass
        idle(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11111111; cycle("t3pre");
        wr_data = 32'hA5A5A5A5; rs1_addr = 5'd7;
        #1 chk("t3_byp1", rs1_data[0], 32'hA5A5A5A5);
        chk("t3_byp0", rs1_data[1], 32'h11111111);
        cycle("t3w");
        idle(); rs1_addr = 5'd7;
        #1 chk("t3_after_byp0", rs1_data[1], 32'hA5A5A5A5);
        cycle("t3r");

        // scoreboard claim / release
        idle(); claim_en = 1'b1; claim_addr = 5'd3;
        #1 chk("t4_claim_ok_free", 32'(claim_ok[0]), 32'd1);
        cycle("t4c");
        idle(); rs2_addr = 5'd3; claim_addr = 5'd3;
        #1 chk("t4_busy", 32'(rs2_busy[0]), 32'd1);
        chk("t4_claim_ok", 32'(claim_ok[0]), 32'd0);
        chk("t4_cnt", 32'(pending_cnt[0]), 32'd1);
        cycle("t4b");
        wr_en = 1'b1; wr_release = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        #1 chk("t4_busy_not_bypassed", 32'(rs2_busy[0]), 32'd1);
        cycle("t4r");
        idle(); rs2_addr = 5'd3;
        #1 chk("t4_busy_clear", 32'(rs2_busy[0]), 32'd0);
        chk("t4_cnt_clear", 32'(pending_cnt[0]), 32'd0);
        cycle("t4d");

        // simultaneous claim and release
        idle(); claim_en = 1'b1; claim_addr = 5'd4; cycle("t5c");
        wr_en = 1'b1; wr_release = 1'b1; wr_addr = 5'd4; wr_data = 32'h44; cycle("t5cr");
        idle(); rs1_addr = 5'd4;
        #1 chk("t5_claim_wins", 32'(rs1_busy[0]), 32'd1);
        chk("t5_cnt_same", 32'(pending_cnt[0]), 32'd1);
        claim_en = 1'b1; claim_addr = 5'd6;
        wr_en = 1'b1; wr_release = 1'b1; wr_addr = 5'd4; wr_data = 32'h45; cycle("t5x");
        idle(); rs1_addr = 5'd4; rs2_addr = 5'd6;
        #1 chk("t5_x4_free", 32'(rs1_busy[0]), 32'd0);
        chk("t5_x6_busy", 32'(rs2_busy[0]), 32'd1);
        chk("t5_cnt_net0", 32'(pending_cnt[0]), 32'd1);
        cycle("t5d");
        wr_en = 1'b1; wr_release = 1'b1; wr_addr = 5'd6; cycle("t5rel");

        // out-of-range indices
        idle(); wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'hCAFEF00D;
        claim_en = 1'b1; claim_addr = 5'd20; rs1_addr = 5'd20;
        #1 chk("t6_illegal16", 32'(illegal_idx[0]), 32'd1);
        chk("t6_illegal32", 32'(illegal_idx[2]), 32'd0);
        chk("t6_rd16", rs1_data[0], 32'd0);
        cycle("t6w");
        idle(); rs1_addr = 5'd20;
        #1 chk("t6_nowrite16", rs1_data[0], 32'd0);
        chk("t6_nocnt16", 32'(pending_cnt[0]), 32'd0);
        chk("t6_write32", rs1_data[2], 32'hCAFEF00D);
        chk("t6_busy32", 32'(rs1_busy[2]), 32'd1);
        cycle("t6r");

        rnd_cycles(600);

        // asynchronous reset mid-run with state present
        idle(); wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99999999;
        claim_en = 1'b1; claim_addr = 5'd2; cycle("t1pre");
        idle(); rs1_addr = 5'd9; rs2_addr = 5'd2;
        #1 chk("t1_pre_rd", rs1_data[0], 32'h99999999);
        rst_n = 1'b0;
        #1 model_reset();
        chk("t1_rs1", rs1_data[0], 32'd0);
        chk("t1_busy", 32'(rs2_busy[0]), 32'd0);
        chk("t1_cnt", 32'(pending_cnt[0]), 32'd0);
        check_all("t1");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        rnd_cycles(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
